// File: rtl/pipe_addsub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_addsub_pkg
//  Description : Shared constants for the pipelined adder/subtractor.
//                OP_ADD / OP_SUB opcode encodings and default geometry.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

endpackage : pipe_addsub_pkg
`default_nettype wire

// File: rtl/pipe_addsub_chunk.sv
`default_nettype none
// ============================================================================
//  Module      : addsub_chunk
//  Description : CW-bit ripple adder slice used by each pipeline stage.
//  Ports       : a, b  - CW-bit operands (b already inverted for subtract)
//                cin   - carry into the slice
//                sum   - CW-bit slice result
//                cout  - carry out of the slice MSB
//  Revision    : 1.0 - initial release
// ============================================================================
module addsub_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};

endmodule : addsub_chunk
`default_nettype wire

// File: rtl/pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_addsub
//  Description : Carry-pipelined WIDTH-bit adder/subtractor. The operation is
//                cut into STAGES slices of CW = WIDTH/STAGES bits; slice k is
//                added in stage k with the carry registered by stage k-1.
//                Valid/ready handshake on both sides, whole pipe stalls
//                together when the output is held.
//  Ports       : clk, rst_n           - clock, synchronous active-low reset
//                in_valid / in_ready  - input handshake
//                op, cin, a, b        - opcode (0 add, 1 sub), carry-in, operands
//                out_valid/out_ready  - output handshake
//                sum, cout, ovf, zero - result and flags
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  // Guarded so a bad STAGES value reports the error below instead of
  // tripping a divide-by-zero first.
  localparam int c_CW   = (STAGES >= 1) ? (WIDTH / STAGES) : 1;
  localparam int c_LAST = (STAGES >= 1) ? (STAGES - 1) : 0;

  if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipe_addsub: WIDTH must be divisible by STAGES and STAGES >= 1");
  end

  // Whole pipeline moves as one; it only freezes when a result is waiting.
  logic w_advance;
  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  // Stage inputs (w_*_in) and registered stage state (r_*). Operands travel
  // at full width; only the slice owned by a stage is consumed there. The
  // partial sum carries finished low slices; bits at and above the current
  // slice are still zero when a stage sees it.
  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic [WIDTH-1:0] w_s_in  [STAGES];
  logic             w_c_in  [STAGES];
  logic             w_v_in  [STAGES];
  logic [c_CW-1:0]  w_chunk [STAGES];
  logic             w_cout  [STAGES];
  logic [WIDTH-1:0] w_s_nxt [STAGES];

  logic [WIDTH-1:0] r_a [STAGES];
  logic [WIDTH-1:0] r_b [STAGES];
  logic [WIDTH-1:0] r_s [STAGES];
  logic             r_c [STAGES];
  logic             r_v [STAGES];
  logic             r_ovf;
  logic             r_zero;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtract is a + ~b + 1: invert b once here and force the carry-in.
      assign w_a_in[k] = a;
      assign w_b_in[k] = (op == OP_SUB) ? ~b : b;
      assign w_c_in[k] = (op == OP_SUB) ? 1'b1 : cin;
      assign w_s_in[k] = '0;
      assign w_v_in[k] = in_valid;
    end else begin : g_rest
      assign w_a_in[k] = r_a[k-1];
      assign w_b_in[k] = r_b[k-1];
      assign w_c_in[k] = r_c[k-1];
      assign w_s_in[k] = r_s[k-1];
      assign w_v_in[k] = r_v[k-1];
    end

    addsub_chunk #(
      .CW   (c_CW)
    ) u_chunk (
      .a    (w_a_in[k][k*c_CW +: c_CW]),
      .b    (w_b_in[k][k*c_CW +: c_CW]),
      .cin  (w_c_in[k]),
      .sum  (w_chunk[k]),
      .cout (w_cout[k])
    );

    assign w_s_nxt[k] = w_s_in[k] | (WIDTH'(w_chunk[k]) << (k * c_CW));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_v[k] <= 1'b0;
        r_s[k] <= '0;
        r_c[k] <= 1'b0;
      end else if (w_advance) begin
        r_v[k] <= w_v_in[k];
        r_a[k] <= w_a_in[k];
        r_b[k] <= w_b_in[k];
        r_s[k] <= w_s_nxt[k];
        r_c[k] <= w_cout[k];
      end
    end
  end

  // Flags come from the complete sum leaving the last slice, so they are
  // registered in the same edge as the final sum.
  logic w_ovf_nxt;
  logic w_zero_nxt;
  assign w_ovf_nxt  = (w_a_in[c_LAST][WIDTH-1] == w_b_in[c_LAST][WIDTH-1]) &&
                      (w_s_nxt[c_LAST][WIDTH-1] != w_a_in[c_LAST][WIDTH-1]);
  assign w_zero_nxt = (w_s_nxt[c_LAST] == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_advance) begin
      r_ovf  <= w_ovf_nxt;
      r_zero <= w_zero_nxt;
    end
  end

  assign out_valid = r_v[c_LAST];
  assign sum       = r_s[c_LAST];
  assign cout      = r_c[c_LAST];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule : pipe_addsub
`default_nettype wire

// File: tb/tb_pipe_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_addsub
//  Description : Self-checking bench for pipe_addsub. Three instances
//                (32/4, 16/2, 64/8) share a clock and reset; each has a
//                queue-based scoreboard fed by an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_addsub;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
    int          stl;
  } ent_t;

  logic clk;
  logic rst_n;

  logic        iv0, ir0, op0, ci0, ov0, or0, co0, of0, z0;
  logic [31:0] a0, b0, s0;
  logic        iv1, ir1, op1, ci1, ov1, or1, co1, of1, z1;
  logic [15:0] a1, b1, s1;
  logic        iv2, ir2, op2, ci2, ov2, or2, co2, of2, z2;
  logic [63:0] a2, b2, s2;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   stalls [3];
  ent_t sb [3][$];
  logic rand_on  = 1'b0;

  pipe_addsub u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .op(op0), .cin(ci0),
    .a(a0), .b(b0), .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0),
    .ovf(of0), .zero(z0));

  pipe_addsub #(.WIDTH(16), .STAGES(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .op(op1), .cin(ci1),
    .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1),
    .ovf(of1), .zero(z1));

  pipe_addsub #(.WIDTH(64), .STAGES(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .op(op2), .cin(ci2),
    .a(a2), .b(b2), .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2),
    .ovf(of2), .zero(z2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: unsigned math for sum/carry, signed math for overflow.
  function automatic ent_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic op, input logic cin);
    ent_t e;
    logic [65:0] ua, ub, ut, m;
    logic signed [65:0] sa, sbv, st, half;
    m    = 66'd1 << w;
    ua   = {2'b00, a};
    ub   = {2'b00, b};
    sa   = $signed(ua << (66 - w)) >>> (66 - w);
    sbv  = $signed(ub << (66 - w)) >>> (66 - w);
    half = $signed(m >> 1);
    if (op == 1'b0) begin
      ut     = ua + ub + {65'd0, cin};
      st     = sa + sbv + $signed({65'd0, cin});
      e.cout = (ut >= m);
    end else begin
      ut     = ua + m - ub;
      st     = sa - sbv;
      e.cout = (ua >= ub);
    end
    ut     = ut & (m - 66'd1);
    e.sum  = ut[63:0];
    e.zero = (ut == '0);
    e.ovf  = (st >= half) || (st < -half);
    e.acc  = 0;
    e.stl  = 0;
    return e;
  endfunction

  function automatic logic [63:0] rnd_op(input int w);
    logic [63:0] r, m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case ($urandom_range(0, 7))
      0:       r = '0;
      1:       r = m;
      2:       r = 64'd1 << (w - 1);
      3:       r = (64'd1 << (w - 1)) - 64'd1;
      4:       r = 64'd1;
      default: r = {$urandom, $urandom};
    endcase
    return r & m;
  endfunction

  // Called on the falling edge: handshakes seen here happen at the next
  // rising edge.
  task automatic mon(input int id, input int w, input int lat,
                     input logic iv, input logic ir, input logic [63:0] a, input logic [63:0] b,
                     input logic op, input logic cin, input logic ov, input logic orr,
                     input logic [63:0] s, input logic co, input logic of, input logic z);
    ent_t e;
    if (!rst_n) begin
      sb[id].delete();
      return;
    end
    chk($sformatf("in_ready[%0d]", id), 64'(ir), 64'(!ov || orr));
    if (sb[id].size() == 0) begin
      chk($sformatf("out_valid_idle[%0d]", id), 64'(ov), 64'(0));
    end else if (ov) begin
      e = sb[id][0];
      chk($sformatf("sum[%0d]", id),  s,       e.sum);
      chk($sformatf("cout[%0d]", id), 64'(co), 64'(e.cout));
      chk($sformatf("ovf[%0d]", id),  64'(of), 64'(e.ovf));
      chk($sformatf("zero[%0d]", id), 64'(z),  64'(e.zero));
      if (orr) begin
        if (e.stl == stalls[id])
          chk($sformatf("latency[%0d]", id), 64'(cyc - e.acc), 64'(lat));
        void'(sb[id].pop_front());
      end else begin
        stalls[id]++;
      end
    end
    if (iv && ir) begin
      e     = model(w, a, b, op, cin);
      e.acc = cyc;
      e.stl = stalls[id];
      sb[id].push_back(e);
    end
  endtask

  always @(negedge clk) begin
    mon(0, 32, 4, iv0, ir0, 64'(a0), 64'(b0), op0, ci0, ov0, or0, 64'(s0), co0, of0, z0);
    mon(1, 16, 2, iv1, ir1, 64'(a1), 64'(b1), op1, ci1, ov1, or1, 64'(s1), co1, of1, z1);
    mon(2, 64, 8, iv2, ir2, a2, b2, op2, ci2, ov2, or2, s2, co2, of2, z2);
    cyc++;
  end

  // Free-running random traffic on the two sweep instances.
  initial begin
    iv1 = 1'b0; or1 = 1'b1; op1 = 1'b0; ci1 = 1'b0; a1 = '0; b1 = '0;
    iv2 = 1'b0; or2 = 1'b1; op2 = 1'b0; ci2 = 1'b0; a2 = '0; b2 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_on) begin
        iv1 = ($urandom_range(0, 3) != 0);
        or1 = ($urandom_range(0, 3) != 0);
        op1 = 1'($urandom_range(0, 1));
        ci1 = 1'($urandom_range(0, 1));
        a1  = 16'(rnd_op(16));
        b1  = 16'(rnd_op(16));
        iv2 = ($urandom_range(0, 3) != 0);
        or2 = ($urandom_range(0, 3) != 0);
        op2 = 1'($urandom_range(0, 1));
        ci2 = 1'($urandom_range(0, 1));
        a2  = rnd_op(64);
        b2  = rnd_op(64);
      end else begin
        iv1 = 1'b0; or1 = 1'b1;
        iv2 = 1'b0; or2 = 1'b1;
      end
    end
  end

  // Present one operand set and hold it until accepted (bounded wait).
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op, input logic cin);
    int t;
    iv0 = 1'b1; a0 = a; b0 = b; op0 = op; ci0 = cin;
    t = 0;
    @(negedge clk);
    while (!ir0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_timeout", 64'(t >= 100), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    iv0 = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv0 = 1'b0; or0 = 1'b1; op0 = 1'b0; ci0 = 1'b0; a0 = '0; b0 = '0;
    stalls[0] = 0; stalls[1] = 0; stalls[2] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // First cycle after release: cleared outputs, ready to accept.
    @(negedge clk);
    chk("rst_out_valid", 64'(ov0), 64'(0));
    chk("rst_sum",       64'(s0),  64'(0));
    chk("rst_cout",      64'(co0), 64'(0));
    chk("rst_ovf",       64'(of0), 64'(0));
    chk("rst_zero",      64'(z0),  64'(0));
    chk("rst_in_ready",  64'(ir0), 64'(1));
    @(posedge clk);
    #1;
    rand_on = 1'b1;

    // Back-to-back adds.
    send(32'd1020, 32'd500, 1'b0, 1'b0);
    send(32'd600, 32'd1000, 1'b0, 1'b0);
    send(32'd50, 32'd150, 1'b0, 1'b0);
    send(32'd90, 32'd10, 1'b0, 1'b0);
    idle(8);

    // Wrap and flag corners, carry-in.
    send(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    send(32'd5, 32'd6, 1'b0, 1'b1);
    send(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1);
    // Subtract; cin must be ignored.
    send(32'h0, 32'h1, 1'b1, 1'b0);
    send(32'd500, 32'd500, 1'b1, 1'b1);
    send(32'h8000_0000, 32'h1, 1'b1, 1'b0);
    send(32'h0, 32'h8000_0000, 1'b1, 1'b0);
    idle(8);

    // Backpressure: fill the pipe, hold the output for five cycles.
    or0 = 1'b0;
    send(32'd11, 32'd22, 1'b0, 1'b0);
    send(32'd33, 32'd44, 1'b1, 1'b0);
    send(32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 1'b1);
    send(32'h1, 32'h2, 1'b1, 1'b0);
    iv0 = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready",  64'(ir0), 64'(0));
      chk("bp_out_valid", 64'(ov0), 64'(1));
    end
    @(posedge clk);
    #1;
    or0 = 1'b1;
    idle(8);
    @(negedge clk);
    chk("bp_drained", 64'(sb[0].size()), 64'(0));
    @(posedge clk);
    #1;

    // Reset with three operations in flight.
    send(32'd1, 32'd1, 1'b0, 1'b0);
    send(32'd2, 32'd2, 1'b0, 1'b0);
    send(32'd3, 32'd3, 1'b0, 1'b0);
    iv0   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_out_valid", 64'(ov0), 64'(0));
    chk("midrst_sum",       64'(s0),  64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(ir0), 64'(1));
    @(posedge clk);
    #1;
    idle(10);

    // Random traffic on the main instance.
    repeat (800) begin
      iv0 = ($urandom_range(0, 3) != 0);
      or0 = ($urandom_range(0, 3) != 0);
      op0 = 1'($urandom_range(0, 1));
      ci0 = 1'($urandom_range(0, 1));
      a0  = 32'(rnd_op(32));
      b0  = 32'(rnd_op(32));
      @(posedge clk);
      #1;
    end

    // Drain everything and confirm nothing was lost.
    rand_on = 1'b0;
    iv0 = 1'b0;
    or0 = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("final_drain0", 64'(sb[0].size()), 64'(0));
    chk("final_drain1", 64'(sb[1].size()), 64'(0));
    chk("final_drain2", 64'(sb[2].size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pipe_addsub
`default_nettype wire
